// File: rtl/axis_uart_rx_if.sv
// AXI-Stream byte channel between the UART receiver and the RX FIFO.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high; while tvalid is high and tready is low the master holds
// tdata and tvalid unchanged; tvalid never depends combinationally on tready.
interface axis_uart_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_rx.sv
// UART receive path: asynchronous serial line in, AXI-Stream byte out.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Optional feature macro UART_RX_GLITCH_FILTER_EN: each bit decision becomes
// the majority of three synchronised samples (mid-1, mid, mid+1), moving the
// decision point one cycle later. Without it a single mid-bit sample is used.
// state_o exposes the FSM state (0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP,
// 5 WAIT) for observation.
module axis_uart_rx #(
   parameter int DATA_WIDTH    = 8,
   parameter int DIVIDER_WIDTH = 32,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
   input  logic                     parity_odd_i,
   input  logic                     parity_even_i,
   input  logic                     uart_rx_i,
   axis_uart_rx_if.master           m_axis,
   output logic                     parity_err_o,
   output logic                     frame_err_o,
   output logic                     overrun_o,
   output logic [2:0]               state_o
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_WAIT   = 3'd5
   } state_t;

   state_t                   state_q, state_d;
   logic [SYNC_STAGES-1:0]   sync_q, sync_d;
   logic [DIVIDER_WIDTH-1:0] div_q, div_d;
   logic [DIVIDER_WIDTH-1:0] baud_q, baud_d;
   logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]    data_q, data_d;
   logic                     par_flag_q, par_flag_d;
   logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;
   logic                     tvalid_q, tvalid_d;
   logic                     par_err_q, par_err_d;
   logic                     frm_err_q, frm_err_d;
   logic                     ovr_q, ovr_d;

   logic                     rx_s;
   logic                     rx_bit;
   logic [DIVIDER_WIDTH-1:0] start_pt;
   logic                     start_tick;
   logic                     bit_tick;
   logic                     parity_en;
   logic                     parity_exp;

   assign rx_s = sync_q[SYNC_STAGES-1];

   // Synchroniser shift: the line enters at bit 0 and leaves as rx_s.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], uart_rx_i};
   end

`ifdef UART_RX_GLITCH_FILTER_EN
   logic [1:0] hist_q, hist_d;

   // Keep the two previous rx_s values so the decision cycle sees three samples.
   always_comb begin
      hist_d = {hist_q[0], rx_s};
   end

   // History register; idles high like the line.
   always_ff @(posedge clk_i) begin
      if (rst_i) hist_q <= 2'b11;
      else       hist_q <= hist_d;
   end

   // Majority vote and decision point one cycle after mid-bit.
   always_comb begin
      rx_bit   = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
      start_pt = div_q >> 1;
   end
`else
   // Single sample taken at mid-bit.
   always_comb begin
      rx_bit   = rx_s;
      start_pt = (div_q >> 1) - DIVIDER_WIDTH'(1);
   end
`endif

   // Sample-point strobes and parity expectation for the bits just shifted in.
   always_comb begin
      start_tick = (baud_q == start_pt);
      bit_tick   = (baud_q == div_q - DIVIDER_WIDTH'(1));
      parity_en  = parity_odd_i | parity_even_i;
      parity_exp = parity_odd_i ? ~(^data_q) : (^data_q);
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state decision.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (!rx_s) state_d = S_START;
         S_START:  if (start_tick) state_d = rx_bit ? S_IDLE : S_DATA;
         S_DATA:   if (bit_tick && (bit_cnt_q == LAST_BIT))
                      state_d = parity_en ? S_PARITY : S_STOP;
         S_PARITY: if (bit_tick) state_d = S_STOP;
         S_STOP:   if (bit_tick) state_d = rx_bit ? S_IDLE : S_WAIT;
         S_WAIT:   if (rx_s) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM outputs: counters, shift register, error flags and output register.
   always_comb begin
      div_d      = div_q;
      baud_d     = baud_q + DIVIDER_WIDTH'(1);
      bit_cnt_d  = bit_cnt_q;
      data_d     = data_q;
      par_flag_d = par_flag_q;
      tdata_d    = tdata_q;
      tvalid_d   = tvalid_q & ~m_axis.tready;
      par_err_d  = 1'b0;
      frm_err_d  = 1'b0;
      ovr_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (!rx_s) begin
               bit_cnt_d  = '0;
               div_d      = clk_divider_i;
               par_flag_d = 1'b0;
            end
         end
         S_START: begin
            if (start_tick) baud_d = '0;
         end
         S_DATA: begin
            if (bit_tick) begin
               baud_d    = '0;
               data_d    = {rx_bit, data_q[DATA_WIDTH-1:1]};
               bit_cnt_d = bit_cnt_q + BW'(1);
            end
         end
         S_PARITY: begin
            if (bit_tick) begin
               baud_d = '0;
               if (rx_bit != parity_exp) par_flag_d = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_tick) begin
               baud_d     = '0;
               par_flag_d = 1'b0;
               if (rx_bit) begin
                  par_err_d = par_flag_q;
                  if (tvalid_q && !m_axis.tready) begin
                     ovr_d = 1'b1;
                  end else begin
                     tdata_d  = data_q;
                     tvalid_d = 1'b1;
                  end
               end else begin
                  frm_err_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            baud_d = '0;
         end
         default: begin
            baud_d = '0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q     <= '1;
         div_q      <= '0;
         baud_q     <= '0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         par_flag_q <= 1'b0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         div_q      <= div_d;
         baud_q     <= baud_d;
         bit_cnt_q  <= bit_cnt_d;
         data_q     <= data_d;
         par_flag_q <= par_flag_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         par_err_q  <= par_err_d;
         frm_err_q  <= frm_err_d;
         ovr_q      <= ovr_d;
      end
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign parity_err_o  = par_err_q;
   assign frame_err_o   = frm_err_q;
   assign overrun_o     = ovr_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Bench for axis_uart_rx: directed scenarios plus randomized frames, checked
// against a frame-level reference model (expected byte queue, error counts).
module tb_axis_uart_rx;

   localparam int DW = 8;
`ifdef UART_RX_GLITCH_FILTER_EN
   localparam int FILT = 1;
`else
   localparam int FILT = 0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [31:0]   clk_divider_i = 32'd16;
   logic          parity_odd_i = 1'b0;
   logic          parity_even_i = 1'b0;
   logic          uart_rx_i = 1'b1;
   logic          parity_err_o;
   logic          frame_err_o;
   logic          overrun_o;
   logic [2:0]    state_o;

   axis_uart_rx_if #(.DATA_WIDTH(DW)) axis_if ();

   axis_uart_rx #(
      .DATA_WIDTH(DW), .DIVIDER_WIDTH(32), .SYNC_STAGES(2)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clk_divider_i (clk_divider_i),
      .parity_odd_i  (parity_odd_i),
      .parity_even_i (parity_even_i),
      .uart_rx_i     (uart_rx_i),
      .m_axis        (axis_if),
      .parity_err_o  (parity_err_o),
      .frame_err_o   (frame_err_o),
      .overrun_o     (overrun_o),
      .state_o       (state_o)
   );

   // Clock and watchdog.
   always #5 clk_i = ~clk_i;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard state.
   int total = 0;
   int bad = 0;
   logic [DW-1:0] exp_q[$];
   int exp_par = 0, exp_frm = 0, exp_ovr = 0;
   int n_par = 0, n_frm = 0, n_ovr = 0, n_beats = 0;
   bit rand_ready = 0;
   int lat = 0;
   int b0 = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitor: count pulses and check every accepted beat against the queue.
   always @(negedge clk_i) begin
      if (parity_err_o) n_par++;
      if (frame_err_o)  n_frm++;
      if (overrun_o)    n_ovr++;
      if (axis_if.tvalid && axis_if.tready) begin
         n_beats++;
         check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("beat_data", 32'(axis_if.tdata), 32'(exp_q.pop_front()));
      end
   end

   // Randomized downstream ready, changed away from both clock edges.
   initial begin
      axis_if.tready = 1'b1;
      forever begin
         @(posedge clk_i);
         #2;
         if (rand_ready) axis_if.tready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk_i);
      #2;
      axis_if.tready = v;
      @(negedge clk_i);
   endtask

   // Driver: one frame on the line; the model is updated before the stop bit
   // because the byte is delivered at mid-stop.
   task automatic send_frame(input logic [7:0] data, input int div, input logic odd,
                             input logic even, input logic bad_par, input logic stop_v,
                             input bit push);
      logic p;
      clk_divider_i = 32'(div);
      parity_odd_i  = odd;
      parity_even_i = even;
      uart_rx_i = 1'b0;
      repeat (div) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
         uart_rx_i = data[i];
         repeat (div) @(negedge clk_i);
      end
      if (odd || even) begin
         p = odd ? ~(^data) : (^data);
         if (bad_par) p = ~p;
         uart_rx_i = p;
         repeat (div) @(negedge clk_i);
      end
      if (stop_v) begin
         if (push) exp_q.push_back(data);
         if ((odd || even) && bad_par) exp_par++;
      end else begin
         exp_frm++;
      end
      uart_rx_i = stop_v;
      repeat (div) @(negedge clk_i);
   endtask

   initial begin
      logic [7:0] rd;
      int         rdiv;
      logic [1:0] pm;
      logic       rbad;

      // Reset state.
      idle(3);
      check("rst_tvalid", 32'(axis_if.tvalid), 32'd0);
      check("rst_tdata", 32'(axis_if.tdata), 32'd0);
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_errs", {29'd0, parity_err_o, frame_err_o, overrun_o}, 32'd0);
      rst_i = 1'b0;
      idle(5);

      // 0xA5, no parity, latency from start edge to tvalid.
      fork
         send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         begin
            lat = 0;
            while (!axis_if.tvalid && lat < 1000) begin
               @(negedge clk_i);
               lat++;
            end
         end
      join
      check("a5_latency", 32'(lat), 32'(3 + 16 / 2 + 9 * 16 + FILT));
      idle(20);
      check("a5_beats", 32'(n_beats), 32'd1);
      check("a5_no_errs", 32'(n_par + n_frm + n_ovr), 32'd0);

      // 0x3C with odd parity and a wrong parity bit.
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(20);
      check("par_err_count", 32'(n_par), 32'(exp_par));
      check("par_beats", 32'(n_beats), 32'd2);

      // False start: line low for 4 cycles only.
      b0 = n_beats;
      uart_rx_i = 1'b0;
      idle(4);
      uart_rx_i = 1'b1;
      idle(48);
      check("false_state", 32'(state_o), 32'd0);
      check("false_beats", 32'(n_beats), 32'(b0));
      check("false_errs", 32'(n_frm + n_ovr), 32'd0);

      // Overrun: hold ready low across two frames.
      set_ready(1'b0);
      b0 = n_beats;
      send_frame(8'h11, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(4);
      exp_ovr++;
      send_frame(8'h22, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(20);
      check("ovr_count", 32'(n_ovr), 32'(exp_ovr));
      check("ovr_tdata_held", 32'(axis_if.tdata), 32'h11);
      check("ovr_tvalid_held", 32'(axis_if.tvalid), 32'd1);
      set_ready(1'b1);
      idle(5);
      check("ovr_beats", 32'(n_beats), 32'(b0 + 1));
      check("ovr_drained", 32'(exp_q.size()), 32'd0);

      // Break: stop bit 0 and line held low for 40 bit times in total.
      send_frame(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(30 * 16);
      check("break_state_wait", 32'(state_o), 32'd5);
      check("break_frm_count", 32'(n_frm), 32'(exp_frm));
      check("break_tvalid", 32'(axis_if.tvalid), 32'd0);
      uart_rx_i = 1'b1;
      idle(20);
      check("break_release", 32'(state_o), 32'd0);
      b0 = n_beats;
      send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(20);
      check("break_next_beat", 32'(n_beats), 32'(b0 + 1));

      // Reset pulse in the middle of the data bits.
      clk_divider_i = 32'd16;
      uart_rx_i = 1'b0;
      idle(16 * 3);
      rst_i = 1'b1;
      idle(1);
      check("midrst_state", 32'(state_o), 32'd0);
      check("midrst_tvalid", 32'(axis_if.tvalid), 32'd0);
      rst_i = 1'b0;
      uart_rx_i = 1'b1;
      idle(20);
      b0 = n_beats;
      send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(20);
      check("midrst_next_beat", 32'(n_beats), 32'(b0 + 1));

      // Randomized frames: data, divider, parity mode, parity corruption, ready.
      rand_ready = 1;
      for (int i = 0; i < 24; i++) begin
         rd   = 8'($urandom);
         rdiv = int'($urandom_range(4, 24));
         pm   = 2'($urandom_range(0, 3));
         rbad = 1'($urandom_range(0, 1));
         send_frame(rd, rdiv, pm[0], pm[1], rbad, 1'b1, 1'b1);
         idle(int'($urandom_range(1, 10)));
      end
      rand_ready = 0;
      set_ready(1'b1);
      idle(50);

      check("final_par", 32'(n_par), 32'(exp_par));
      check("final_frm", 32'(n_frm), 32'(exp_frm));
      check("final_ovr", 32'(n_ovr), 32'(exp_ovr));
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
